// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Wide enough for LOAD_USE_BUBBLES-1 with LOAD_USE_BUBBLES up to 4.
   localparam int BUB_W = 2;

   function automatic logic reg_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
      return uses && (rs == rd);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubbles, taken-branch squash and
// data-memory wait freeze, with saturating performance counters.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int MEM_TIMEOUT      = 64,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             uses_rs1_ID,
   input  logic             uses_rs2_ID,
   input  logic [4:0]       rd_EX,
   input  logic             mem_read_EX,
   input  logic             branch_taken_EX,
   input  logic             dmem_req_MEM,
   input  logic             dmem_ready,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             bubble_EX,
   output logic             flush_ID,
   output logic             freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e          state_q, state_d;
   logic [BUB_W-1:0]   rem_q, rem_d;
   logic               mem_timeout_q, mem_timeout_d;
   logic [WAIT_W-1:0]  wait_cnt_s;
   logic               luh_s, mw_s;
   logic               stall_s, bubble_s, flush_s, freeze_s;

   assign luh_s = mem_read_EX && (rd_EX != REG_ZERO) &&
                  (reg_match(uses_rs1_ID, rs1_ID, rd_EX) || reg_match(uses_rs2_ID, rs2_ID, rd_EX));
   assign mw_s  = dmem_req_MEM && !dmem_ready;

   // Next state and Mealy controls; memory wait outranks branch outranks load-use.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      stall_s  = 1'b0;
      bubble_s = 1'b0;
      flush_s  = 1'b0;
      freeze_s = 1'b0;
      if (rst) begin
         state_d = RUN;
         rem_d   = '0;
      end else if (mw_s) begin
         freeze_s = 1'b1;
         state_d  = MEM_WAIT;
         rem_d    = '0;
      end else if (branch_taken_EX) begin
         flush_s  = 1'b1;
         bubble_s = 1'b1;
         state_d  = RUN;
         rem_d    = '0;
      end else begin
         case (state_q)
            LOAD_STALL: begin
               stall_s  = 1'b1;
               bubble_s = 1'b1;
               rem_d    = rem_q - BUB_W'(1);
               if (rem_q <= BUB_W'(1)) begin
                  state_d = RUN;
               end else begin
                  state_d = LOAD_STALL;
               end
            end
            default: begin
               // RUN, and the release cycle of MEM_WAIT, follow the same rules.
               state_d = RUN;
               if (luh_s) begin
                  stall_s  = 1'b1;
                  bubble_s = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_d = LOAD_STALL;
                     rem_d   = BUB_W'(LOAD_USE_BUBBLES - 1);
                  end else begin
                     rem_d   = '0;
                  end
               end else begin
                  rem_d = '0;
               end
            end
         endcase
      end
   end

   // The wait counter holds the length of the current wait after this edge.
   always_comb begin
      if (mw_s && (wait_cnt_s >= WAIT_W'(MEM_TIMEOUT - 1))) begin
         mem_timeout_d = 1'b1;
      end else begin
         mem_timeout_d = mem_timeout_q;
      end
   end

   // State, bubble countdown and sticky timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         rem_q         <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst || !mw_s),
      .inc   (mw_s),
      .count (wait_cnt_s)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_s || freeze_s),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_s),
      .count (flush_count)
   );

   assign stall_IF    = stall_s;
   assign stall_ID    = stall_s;
   assign bubble_EX   = bubble_s;
   assign flush_ID    = flush_s;
   assign freeze      = freeze_s;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two configurations driven in lockstep,
// a directed vector table, hand sequences and random traffic vs a model.
module tb_hazard_control_unit;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       req;
      logic       rdy;
   } in_t;

   typedef struct {
      in_t        i;
      logic [4:0] o;   // {stall_IF, stall_ID, bubble_EX, flush_ID, freeze}
      int         sc;
      int         fc;
   } vec_t;

   typedef struct {
      int     mode;    // 0 running, 1 inserting load bubbles, 2 memory wait
      int     left;
      int     wlen;
      bit     tmo;
      longint stalls;
      longint flushes;
   } mst_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, u1, u2, mr, br, req, rdy;
   logic [4:0] rs1, rs2, rd;

   logic [4:0]  ctl_a, ctl_b;
   logic        tmo_a, tmo_b;
   logic [7:0]  sc_a, fc_a;
   logic [31:0] sc_b, fc_b;

   hazard_control_unit #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .rs1_ID(rs1), .rs2_ID(rs2), .uses_rs1_ID(u1), .uses_rs2_ID(u2),
      .rd_EX(rd), .mem_read_EX(mr), .branch_taken_EX(br), .dmem_req_MEM(req), .dmem_ready(rdy),
      .stall_IF(ctl_a[4]), .stall_ID(ctl_a[3]), .bubble_EX(ctl_a[2]), .flush_ID(ctl_a[1]),
      .freeze(ctl_a[0]), .mem_timeout(tmo_a), .stall_cycles(sc_a), .flush_count(fc_a));

   hazard_control_unit #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(64), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .rs1_ID(rs1), .rs2_ID(rs2), .uses_rs1_ID(u1), .uses_rs2_ID(u2),
      .rd_EX(rd), .mem_read_EX(mr), .branch_taken_EX(br), .dmem_req_MEM(req), .dmem_ready(rdy),
      .stall_IF(ctl_b[4]), .stall_ID(ctl_b[3]), .bubble_EX(ctl_b[2]), .flush_ID(ctl_b[1]),
      .freeze(ctl_b[0]), .mem_timeout(tmo_b), .stall_cycles(sc_b), .flush_count(fc_b));

   int   n_vec  = 0;
   int   n_miss = 0;
   mst_t ms [2];
   int   p_lub [2] = '{3, 1};
   int   p_mt  [2] = '{4, 64};
   int   p_cw  [2] = '{8, 32};
   logic [4:0] samp_a, samp_b;

   function automatic in_t mkin(logic r, logic [4:0] a1, logic e1, logic [4:0] a2, logic e2,
                                logic [4:0] d, logic m, logic b, logic q, logic y);
      in_t v;
      v.rst = r; v.rs1 = a1; v.u1 = e1; v.rs2 = a2; v.u2 = e2; v.rd = d;
      v.mr = m; v.br = b; v.req = q; v.rdy = y;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: what the controls should be this cycle for configuration k.
   function automatic logic [4:0] model_out(int k, in_t v);
      bit hz = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      bit wt = v.req && !v.rdy;
      if (v.rst) return 5'b00000;
      if (wt)    return 5'b00001;
      if (v.br)  return 5'b00110;
      if (ms[k].mode == 1 || hz) return 5'b11100;
      return 5'b00000;
   endfunction

   task automatic model_commit(int k, in_t v, logic [4:0] o);
      bit     hz  = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      bit     wt  = v.req && !v.rdy;
      longint cap = (64'd1 << p_cw[k]) - 1;
      if (v.rst) begin
         ms[k] = '{0, 0, 0, 1'b0, 0, 0};
         return;
      end
      if ((o[4] || o[0]) && ms[k].stalls < cap) ms[k].stalls++;
      if (o[1] && ms[k].flushes < cap) ms[k].flushes++;
      if (wt) begin
         ms[k].wlen++;
         if (ms[k].wlen >= p_mt[k]) ms[k].tmo = 1'b1;
      end else begin
         ms[k].wlen = 0;
      end
      if (wt) begin
         ms[k].mode = 2; ms[k].left = 0;
      end else if (v.br) begin
         ms[k].mode = 0;
      end else if (ms[k].mode == 1) begin
         ms[k].left--;
         if (ms[k].left == 0) ms[k].mode = 0;
      end else if (hz && p_lub[k] > 1) begin
         ms[k].mode = 1; ms[k].left = p_lub[k] - 1;
      end else begin
         ms[k].mode = 0;
      end
   endtask

   // One clock: drive, check Mealy controls mid-cycle, then check registered state.
   task automatic cyc(input in_t v);
      logic [4:0] oa, ob;
      @(negedge clk);
      rst = v.rst; rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2; rd = v.rd;
      mr = v.mr; br = v.br; req = v.req; rdy = v.rdy;
      #1;
      samp_a = ctl_a;
      samp_b = ctl_b;
      oa = model_out(0, v);
      ob = model_out(1, v);
      chk("mdl_ctl_a", samp_a, oa);
      chk("mdl_ctl_b", samp_b, ob);
      @(posedge clk);
      model_commit(0, v, oa);
      model_commit(1, v, ob);
      #1;
      chk("mdl_cnt_a", {16'd0, sc_a, 8'd0, fc_a, 23'd0, tmo_a},
          {16'd0, ms[0].stalls[7:0], 8'd0, ms[0].flushes[7:0], 23'd0, ms[0].tmo});
      chk("mdl_stall_b", sc_b, ms[1].stalls);
      chk("mdl_flush_b", fc_b, ms[1].flushes);
      chk("mdl_tmo_b", tmo_b, ms[1].tmo);
   endtask

   in_t  IDLE, RST, LUH, MW, RDY, rv;
   vec_t tbl [16];

   initial begin
      IDLE = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      RST  = mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      LUH  = mkin(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);
      MW   = mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      RDY  = mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; mr = 0; br = 0; req = 0; rdy = 0;
      for (int k = 0; k < 2; k++) ms[k] = '{0, 0, 0, 1'b0, 0, 0};

      // Expectations here are for the single-bubble configuration (dut_b).
      tbl[0]  = '{mkin(1, 5, 1, 0, 0, 5, 1, 1, 1, 0), 5'b00000, 0, 0};
      tbl[1]  = '{LUH,                                5'b11100, 1, 0};
      tbl[2]  = '{IDLE,                               5'b00000, 1, 0};
      tbl[3]  = '{mkin(0, 0, 1, 0, 0, 0, 1, 0, 0, 0), 5'b00000, 1, 0};
      tbl[4]  = '{mkin(0, 0, 0, 7, 1, 7, 1, 0, 0, 0), 5'b11100, 2, 0};
      tbl[5]  = '{mkin(0, 0, 0, 7, 0, 7, 1, 0, 0, 0), 5'b00000, 2, 0};
      tbl[6]  = '{mkin(0, 5, 1, 0, 0, 5, 1, 1, 0, 0), 5'b00110, 2, 1};
      tbl[7]  = '{MW,                                 5'b00001, 3, 1};
      tbl[8]  = '{MW,                                 5'b00001, 4, 1};
      tbl[9]  = '{MW,                                 5'b00001, 5, 1};
      tbl[10] = '{MW,                                 5'b00001, 6, 1};
      tbl[11] = '{MW,                                 5'b00001, 7, 1};
      tbl[12] = '{RDY,                                5'b00000, 7, 1};
      tbl[13] = '{mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 5'b00001, 8, 1};
      tbl[14] = '{mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 5'b00110, 8, 2};
      tbl[15] = '{mkin(0, 5, 1, 0, 0, 5, 1, 0, 1, 0), 5'b00001, 9, 2};
      for (int n = 0; n < 16; n++) begin
         cyc(tbl[n].i);
         chk($sformatf("tbl%0d_ctl", n), samp_b, tbl[n].o);
         chk($sformatf("tbl%0d_stall", n), sc_b, tbl[n].sc);
         chk($sformatf("tbl%0d_flush", n), fc_b, tbl[n].fc);
         chk($sformatf("tbl%0d_tmo", n), tmo_b, 0);
      end

      // Three-bubble load-use run.
      cyc(RST);
      cyc(LUH);  chk("lub3_c1", samp_a, 5'b11100);
      cyc(IDLE); chk("lub3_c2", samp_a, 5'b11100);
      cyc(IDLE); chk("lub3_c3", samp_a, 5'b11100);
      cyc(IDLE); chk("lub3_c4", samp_a, 5'b00000);
      chk("lub3_cnt", sc_a, 3);

      // Memory wait aborts the remaining bubbles.
      cyc(RST);
      cyc(LUH);  chk("abort_c1", samp_a, 5'b11100);
      cyc(MW);   chk("abort_c2", samp_a, 5'b00001);
      cyc(RDY);  chk("abort_c3", samp_a, 5'b00000);
      cyc(IDLE); chk("abort_c4", samp_a, 5'b00000);
      chk("abort_cnt", sc_a, 2);

      // Timeout after the 4th wait cycle, sticky until reset.
      cyc(RST);
      for (int w = 1; w <= 6; w++) begin
         cyc(MW);
         chk($sformatf("tmo_w%0d", w), tmo_a, (w >= 4));
      end
      cyc(RDY);  chk("tmo_rdy_ctl", samp_a, 5'b00000);
      chk("tmo_rdy_flag", tmo_a, 1);
      chk("tmo_stall_cnt", sc_a, 6);
      cyc(IDLE); chk("tmo_hold", tmo_a, 1);
      cyc(RST);  chk("tmo_rst_ctl", samp_a, 5'b00000);
      chk("tmo_clear", tmo_a, 0);

      // Reset in the 3rd wait cycle, then a normal load-use stall.
      cyc(RST);
      cyc(MW);
      cyc(MW);
      cyc(mkin(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); chk("rstw_ctl", samp_a, 5'b00000);
      chk("rstw_cnt", {sc_a, fc_a}, 16'd0);
      cyc(LUH);  chk("rstw_luh", samp_a, 5'b11100);
      chk("rstw_stall", sc_a, 1);

      // Random traffic against the model; small register range to provoke matches.
      for (int n = 0; n < 1500; n++) begin
         rv.rst = ($urandom_range(79) == 0);
         rv.rs1 = 5'($urandom_range(3));
         rv.rs2 = 5'($urandom_range(3));
         rv.rd  = 5'($urandom_range(3));
         rv.u1  = 1'($urandom_range(1));
         rv.u2  = 1'($urandom_range(1));
         rv.mr  = 1'($urandom_range(1));
         rv.br  = ($urandom_range(5) == 0);
         rv.req = ($urandom_range(2) == 0);
         rv.rdy = (n < 750) ? ($urandom_range(3) == 0) : 1'($urandom_range(1));
         cyc(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
